// File: rtl/rotor_return_pkg.sv
// rtl/rotor_return_pkg.sv - shared letter type, rotor/inverse tables, plugboard pairs and helpers
package rotor_return_pkg;

  localparam int ALPHA = 26;
  localparam int PLUG_N = 6;

  typedef logic [4:0] letter_t;

  // Forward wirings as letter codes (1..26); index 0 = position a
  localparam letter_t FWD1 [ALPHA] = '{
    5'd10, 5'd7,  5'd4,  5'd17, 5'd15, 5'd24, 5'd21, 5'd19, 5'd3,  5'd1,
    5'd13, 5'd9,  5'd6,  5'd18, 5'd22, 5'd20, 5'd16, 5'd14, 5'd5,  5'd23,
    5'd11, 5'd2,  5'd12, 5'd26, 5'd25, 5'd8
  };
  localparam letter_t FWD2 [ALPHA] = '{
    5'd14, 5'd20, 5'd26, 5'd16, 5'd19, 5'd6,  5'd2,  5'd15, 5'd11, 5'd13,
    5'd23, 5'd18, 5'd3,  5'd10, 5'd4,  5'd9,  5'd22, 5'd12, 5'd1,  5'd5,
    5'd25, 5'd21, 5'd24, 5'd8,  5'd7,  5'd17
  };

  // Inverse wirings as 0-based indices: INV[k] = j where FWD[j] = k+1
  localparam letter_t INV1 [ALPHA] = '{
    5'd9,  5'd21, 5'd8,  5'd2,  5'd18, 5'd12, 5'd1,  5'd25, 5'd11, 5'd0,
    5'd20, 5'd22, 5'd10, 5'd17, 5'd4,  5'd16, 5'd3,  5'd13, 5'd7,  5'd15,
    5'd6,  5'd14, 5'd19, 5'd5,  5'd24, 5'd23
  };
  localparam letter_t INV2 [ALPHA] = '{
    5'd18, 5'd6,  5'd12, 5'd14, 5'd19, 5'd5,  5'd24, 5'd23, 5'd15, 5'd13,
    5'd8,  5'd17, 5'd9,  5'd0,  5'd7,  5'd3,  5'd25, 5'd11, 5'd4,  5'd1,
    5'd21, 5'd16, 5'd10, 5'd22, 5'd20, 5'd2
  };

  // Reciprocal plugboard pairs: a-b, k-m, l-y, e-u, o-p, r-s
  localparam letter_t PLUG_A [PLUG_N] = '{5'd1, 5'd11, 5'd12, 5'd5,  5'd15, 5'd18};
  localparam letter_t PLUG_B [PLUG_N] = '{5'd2, 5'd13, 5'd25, 5'd21, 5'd16, 5'd19};

  function automatic logic is_illegal(input letter_t x);
    return (x == 5'd0) || (x > 5'(ALPHA));
  endfunction

  // Inverse rotor for a legal letter x (1..26) at position p (0..25); 6-bit sum avoids overflow
  function automatic letter_t inv_map(input logic use_r2, input letter_t x, input letter_t p);
    logic [5:0] s;
    letter_t    v;
    letter_t    r;
    s = {1'b0, x} - 6'd1 + {1'b0, p};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    v = use_r2 ? INV2[s[4:0]] : INV1[s[4:0]];
    r = (v >= p) ? (v - p) : (v + 5'(ALPHA) - p);
    return r + 5'd1;
  endfunction

  function automatic letter_t plug_swap(input letter_t x);
    letter_t r;
    r = x;
    for (int i = 0; i < PLUG_N; i++) begin
      if (x == PLUG_A[i]) r = PLUG_B[i];
      else if (x == PLUG_B[i]) r = PLUG_A[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rotor_return_inv_stage.sv
// rtl/rotor_return_inv_stage.sv - one registered inverse-rotor stage with valid/ready handshake
module rotor_inv_stage
  import rotor_return_pkg::*;
#(
  parameter bit USE_ROTOR2 = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  output logic    in_ready,
  input  letter_t in_char,
  input  logic    in_err,
  input  letter_t pos,
  output logic    out_valid,
  input  logic    out_ready,
  output letter_t out_char,
  output logic    out_err
);

  logic    valid_q, valid_d;
  letter_t char_q, char_d;
  logic    err_q, err_d;
  logic    advance;

  // The register may take new data when empty or when its content leaves this cycle
  assign advance   = !valid_q || out_ready;
  assign in_ready  = rst_n && advance;
  assign out_valid = valid_q;
  assign out_char  = char_q;
  assign out_err   = err_q;

  // Next-state: load mapped letter on advance, otherwise hold (keeps output stable under stall)
  always_comb begin
    valid_d = valid_q;
    char_d  = char_q;
    err_d   = err_q;
    if (advance) begin
      valid_d = in_valid;
      if (in_valid) begin
        err_d  = in_err;
        char_d = in_err ? in_char : inv_map(USE_ROTOR2, in_char, pos);
      end
    end
  end

  // Stage register; reset empties it and clears the payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      char_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      char_q  <= char_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/rotor_return.sv
// rtl/rotor_return.sv - two-stage inverse rotor return path; optional plugboard via ROTOR_RETURN_PLUG_EN
module rotor_return
  import rotor_return_pkg::*;
#(
  parameter int R1_INIT = 3,
  parameter int R2_INIT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_char,
  output logic       out_err,
  input  logic       load,
  input  logic [4:0] pos1_ld,
  input  logic [4:0] pos2_ld,
  output logic [4:0] pos1,
  output logic [4:0] pos2
);

  localparam letter_t R1_RST = letter_t'(R1_INIT);
  localparam letter_t R2_RST = letter_t'(R2_INIT);

  letter_t pos1_q, pos1_d;
  letter_t pos2_q, pos2_d;
  letter_t pos1_pipe_q, pos1_pipe_d;
  logic    accept;

  logic    s1_valid, s1_err, s2_ready, s2_err;
  letter_t s1_char, s2_char;

  assign accept = in_valid && in_ready;
  assign pos1   = pos1_q;
  assign pos2   = pos2_q;

  // Rotor stepping with carry; a valid load overrides stepping, an out-of-range load value holds
  always_comb begin
    pos1_d = pos1_q;
    pos2_d = pos2_q;
    if (accept) begin
      if (pos1_q == 5'(ALPHA - 1)) begin
        pos1_d = '0;
        pos2_d = (pos2_q == 5'(ALPHA - 1)) ? '0 : pos2_q + 5'd1;
      end else begin
        pos1_d = pos1_q + 5'd1;
      end
    end
    if (load) begin
      pos1_d = (pos1_ld < 5'(ALPHA)) ? pos1_ld : pos1_q;
      pos2_d = (pos2_ld < 5'(ALPHA)) ? pos2_ld : pos2_q;
    end
  end

  // Rotor-1 position rides alongside stage 1; stage 1 captures exactly on accept
  always_comb begin
    pos1_pipe_d = accept ? pos1_q : pos1_pipe_q;
  end

  // Rotor position and carried-position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos1_q      <= R1_RST;
      pos2_q      <= R2_RST;
      pos1_pipe_q <= '0;
    end else begin
      pos1_q      <= pos1_d;
      pos2_q      <= pos2_d;
      pos1_pipe_q <= pos1_pipe_d;
    end
  end

  rotor_inv_stage #(.USE_ROTOR2(1'b1)) u_stage_r2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .in_err    (is_illegal(in_char)),
    .pos       (pos2_q),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_char  (s1_char),
    .out_err   (s1_err)
  );

  rotor_inv_stage #(.USE_ROTOR2(1'b0)) u_stage_r1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_char   (s1_char),
    .in_err    (s1_err),
    .pos       (pos1_pipe_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (s2_char),
    .out_err   (s2_err)
  );

  assign out_err = s2_err;

`ifdef ROTOR_RETURN_PLUG_EN
  assign out_char = s2_err ? s2_char : plug_swap(s2_char);
`else
  assign out_char = s2_char;
`endif

endmodule

// File: tb/tb_rotor_return.sv
// tb/tb_rotor_return.sv - directed self-checking bench for rotor_return
module tb_rotor_return;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_char = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_char;
  logic       out_err;
  logic       load = 1'b0;
  logic [4:0] pos1_ld = '0;
  logic [4:0] pos2_ld = '0;
  logic [4:0] pos1;
  logic [4:0] pos2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam string FWD1_S = "JGDQOXUSCAMIFRVTPNEWKBLZYH";
  localparam string FWD2_S = "NTZPSFBOKMWRCJDIVLAEYUXHGQ";

  always #5 clk = ~clk;

  rotor_return dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_err   (out_err),
    .load      (load),
    .pos1_ld   (pos1_ld),
    .pos2_ld   (pos2_ld),
    .pos1      (pos1),
    .pos2      (pos2)
  );

  function automatic int fwd_val(input int sel, input int j);
    if (sel == 1) return int'(FWD1_S[j]) - 64;
    return int'(FWD2_S[j]) - 64;
  endfunction

  function automatic int inv_stage(input int sel, input int x, input int p);
    int k, jj;
    k = (x - 1 + p) % 26;
    jj = 0;
    for (int j = 0; j < 26; j++) if (fwd_val(sel, j) == k + 1) jj = j;
    return ((jj - p + 26) % 26) + 1;
  endfunction

  function automatic int tb_plug(input int x);
    case (x)
      1: return 2;   2: return 1;   11: return 13; 13: return 11;
      12: return 25; 25: return 12; 5: return 21;  21: return 5;
      15: return 16; 16: return 15; 18: return 19; 19: return 18;
      default: return x;
    endcase
  endfunction

  function automatic int model(input int x, input int p1, input int p2);
    int r;
    if (x < 1 || x > 26) return x;
    r = inv_stage(1, inv_stage(2, x, p2), p1);
`ifdef ROTOR_RETURN_PLUG_EN
    r = tb_plug(r);
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int p1, input int p2);
    load = 1'b1; pos1_ld = 5'(p1); pos2_ld = 5'(p2);
    step();
    load = 1'b0;
  endtask

  task automatic send(input int ch);
    in_valid = 1'b1; in_char = 5'(ch);
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (out_char !== 5'd0) begin n_bad++; $display("FAIL reset_out_char got %0d want 0", out_char); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %0b want 0", out_err); end
    n_cmp++; if (pos1 !== 5'd3) begin n_bad++; $display("FAIL reset_pos1 got %0d want 3", pos1); end
    n_cmp++; if (pos2 !== 5'd7) begin n_bad++; $display("FAIL reset_pos2 got %0d want 7", pos2); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_load(0, 0);
    in_valid = 1'b1; in_char = 5'd1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (pos1 !== 5'd1) begin n_bad++; $display("FAIL basic_pos1 got %0d want 1", pos1); end
    n_cmp++; if (pos2 !== 5'd0) begin n_bad++; $display("FAIL basic_pos2 got %0d want 0", pos2); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_char !== 5'd8) begin n_bad++; $display("FAIL basic_char got %0d want 8", out_char); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0b want 0", out_err); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained got %0b want 0", out_valid); end
    step();
  endtask

  task automatic test_pos2();
    logic [4:0] exp_c;
`ifdef ROTOR_RETURN_PLUG_EN
    exp_c = 5'd11;
`else
    exp_c = 5'd13;
`endif
    do_load(0, 1);
    send(1);
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_char !== exp_c) begin n_bad++; $display("FAIL pos2_char got v=%0b c=%0d want v=1 c=%0d", out_valid, out_char, exp_c); end
    step();
  endtask

  task automatic test_wrap();
    do_load(25, 25);
    send(5);
    @(negedge clk);
    n_cmp++; if (pos1 !== 5'd0) begin n_bad++; $display("FAIL wrap_pos1 got %0d want 0", pos1); end
    n_cmp++; if (pos2 !== 5'd0) begin n_bad++; $display("FAIL wrap_pos2 got %0d want 0", pos2); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_char !== 5'd6) begin n_bad++; $display("FAIL wrap_char got v=%0b c=%0d want v=1 c=6", out_valid, out_char); end
    step();
  endtask

  task automatic test_illegal();
    do_load(10, 2);
    send(0);
    @(negedge clk);
    n_cmp++; if (pos1 !== 5'd11) begin n_bad++; $display("FAIL illegal_pos1 got %0d want 11", pos1); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_char !== 5'd0 || out_err !== 1'b1) begin n_bad++; $display("FAIL illegal_zero got v=%0b c=%0d e=%0b want v=1 c=0 e=1", out_valid, out_char, out_err); end
    send(27);
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_char !== 5'd27 || out_err !== 1'b1) begin n_bad++; $display("FAIL illegal_27 got v=%0b c=%0d e=%0b want v=1 c=27 e=1", out_valid, out_char, out_err); end
    n_cmp++; if (pos1 !== 5'd12) begin n_bad++; $display("FAIL illegal_pos1b got %0d want 12", pos1); end
    step();
  endtask

  task automatic test_load_accept();
    do_load(0, 0);
    load = 1'b1; pos1_ld = 5'd5; pos2_ld = 5'd6;
    in_valid = 1'b1; in_char = 5'd1;
    step();
    load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (pos1 !== 5'd5 || pos2 !== 5'd6) begin n_bad++; $display("FAIL ldacc_pos got %0d/%0d want 5/6", pos1, pos2); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_char !== 5'd8) begin n_bad++; $display("FAIL ldacc_char got v=%0b c=%0d want v=1 c=8", out_valid, out_char); end
    step();
    do_load(30, 3);
    @(negedge clk);
    n_cmp++; if (pos1 !== 5'd5 || pos2 !== 5'd3) begin n_bad++; $display("FAIL ld_range1 got %0d/%0d want 5/3", pos1, pos2); end
    step();
    do_load(2, 26);
    @(negedge clk);
    n_cmp++; if (pos1 !== 5'd2 || pos2 !== 5'd3) begin n_bad++; $display("FAIL ld_range2 got %0d/%0d want 2/3", pos1, pos2); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_c [3];
`ifdef ROTOR_RETURN_PLUG_EN
    exp_c = '{5'd8, 5'd16, 5'd21};
`else
    exp_c = '{5'd8, 5'd15, 5'd5};
`endif
    out_ready = 1'b1;
    do_load(0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3); in_char = 5'd1;
      @(negedge clk);
      if (i < 3) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); end
      end
      if (i >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_char !== exp_c[i-2]) begin n_bad++; $display("FAIL b2b_out[%0d] got v=%0b c=%0d want v=1 c=%0d", i - 2, out_valid, out_char, exp_c[i-2]); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [4:0] chars [10];
    int exp_c [$];
    int exp_e [$];
    int p1, p2, got;
    chars = '{5'd1, 5'd2, 5'd26, 5'd13, 5'd7, 5'd19, 5'd31, 5'd25, 5'd4, 5'd11};
    do_load(22, 25);
    p1 = 22; p2 = 25; got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic rdy, acc;
          int cyc;
          in_valid = 1'b1; in_char = chars[i];
          acc = 1'b0; cyc = 0;
          while (!acc && cyc < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
              exp_c.push_back(model(int'(chars[i]), p1, p2));
              exp_e.push_back((chars[i] == 0 || chars[i] > 26) ? 1 : 0);
              if (p1 == 25) begin p1 = 0; p2 = (p2 == 25) ? 0 : p2 + 1; end
              else p1 = p1 + 1;
              acc = 1'b1;
            end
            #1;
            cyc++;
          end
          if (!acc) begin n_cmp++; n_bad++; $display("FAIL stream_accept[%0d] got timeout want accept", i); end
        end
        in_valid = 1'b0;
      end
      begin
        logic stalled;
        logic [4:0] held_c;
        logic held_e;
        int ocyc;
        stalled = 1'b0; held_c = '0; held_e = 1'b0; ocyc = 0;
        while (got < 10 && ocyc < 100) begin
          out_ready = (ocyc % 2 == 0);
          @(negedge clk);
          if (out_valid) begin
            if (stalled) begin
              n_cmp++; if (out_char !== held_c || out_err !== held_e) begin n_bad++; $display("FAIL stream_stable got c=%0d e=%0b want c=%0d e=%0b", out_char, out_err, held_c, held_e); end
            end
            if (out_ready) begin
              n_cmp++;
              if (exp_c.size() == 0) begin n_bad++; $display("FAIL stream_extra got c=%0d want none", out_char); end
              else begin
                int ec, ee;
                ec = exp_c.pop_front(); ee = exp_e.pop_front();
                if (int'(out_char) != ec || int'(out_err) != ee) begin n_bad++; $display("FAIL stream_out[%0d] got c=%0d e=%0b want c=%0d e=%0d", got, out_char, out_err, ec, ee); end
              end
              got++;
              stalled = 1'b0;
            end else begin
              stalled = 1'b1; held_c = out_char; held_e = out_err;
            end
          end else begin
            stalled = 1'b0;
          end
          @(posedge clk);
          #1;
          ocyc++;
        end
      end
    join
    out_ready = 1'b1;
    n_cmp++; if (got != 10) begin n_bad++; $display("FAIL stream_count got %0d want 10", got); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_dup got v=%0b want 0", out_valid); end
    step();
  endtask

  task automatic test_reset_inflight();
    logic seen;
    out_ready = 1'b0;
    do_load(0, 0);
    send(1);
    send(2);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL inflight_pre got v=%0b want 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL inflight_rst got v=%0b r=%0b want 0/0", out_valid, in_ready); end
    n_cmp++; if (out_char !== 5'd0 || out_err !== 1'b0) begin n_bad++; $display("FAIL inflight_rst_data got c=%0d e=%0b want 0/0", out_char, out_err); end
    n_cmp++; if (pos1 !== 5'd3 || pos2 !== 5'd7) begin n_bad++; $display("FAIL inflight_rst_pos got %0d/%0d want 3/7", pos1, pos2); end
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL inflight_stale got %0b want 0", seen); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pos2();
    test_wrap();
    test_illegal();
    test_load_accept();
    test_back_to_back();
    test_stream();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
